// File: rtl/dfr_reservoir_engine.sv
// ---------------------------------------------------------------------------
// dfr_reservoir_engine
//
// Responder side of the reservoir handshake driven by the DFR core controller.
// Owns the virtual-node state vector, the warm-up (INIT) and test (TEST)
// sample counters, and the phase flags that the controller sees as
// busy/filled. Each reservoir_en pulse runs one masked time-step over all
// virtual nodes:
//   1. read one input sample u from the synchronous sample RAM
//   2. update one node per cycle with
//        x_k <= sat(term_k + (x_k >>> FEEDBACK_SHIFT)), term_k = MASK[k] ? u : -u
//   3. optionally stream the new node values into the history RAM
//   4. pulse reservoir_valid for one cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reservoir_rst            clear node states and abort a running step
//   reservoir_en             start one time-step (ignored unless idle)
//   init_sample_cntr_rst     enter INIT phase, clear init counter
//   sample_cntr_rst          enter TEST phase, clear sample counter
//   sample_cntr_en           advance the counter of the current phase
//   reservoir_history_en     request history writes for the step being started
//   reservoir_busy           TEST phase with samples outstanding
//   reservoir_init_busy      INIT phase with warm-up samples outstanding
//   reservoir_filled         TEST phase reached
//   reservoir_valid          one-cycle step-complete pulse
//   sample_rd_en/addr/data   sample RAM read port (data one cycle after en)
//   hist_wr_en/addr/data     history RAM write port
// ---------------------------------------------------------------------------
module dfr_reservoir_engine #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int VIRTUAL_NODES    = 10,
    parameter int NUM_INIT_SAMPLES = 10,
    parameter int NUM_SAMPLES      = 100,
    parameter int FEEDBACK_SHIFT   = 1,
    parameter logic [VIRTUAL_NODES-1:0] MASK = VIRTUAL_NODES'(10'h155)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         reservoir_rst,
    input  logic                         reservoir_en,
    input  logic                         init_sample_cntr_rst,
    input  logic                         sample_cntr_rst,
    input  logic                         sample_cntr_en,
    input  logic                         reservoir_history_en,
    output logic                         reservoir_busy,
    output logic                         reservoir_init_busy,
    output logic                         reservoir_filled,
    output logic                         reservoir_valid,
    output logic                         sample_rd_en,
    output logic [ADDR_WIDTH-1:0]        sample_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] sample_rd_data,
    output logic                         hist_wr_en,
    output logic [ADDR_WIDTH-1:0]        hist_wr_addr,
    output logic signed [DATA_WIDTH-1:0] hist_wr_data
);

    localparam int KW = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1;
    // Two guard bits: |term| and |feedback| are each at most 2^(DW-1).
    localparam int EW = DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_VALID  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_TEST = 2'd2
    } phase_t;

    state_t                         state_r;
    state_t                         state_s;
    phase_t                         phase_r;
    logic [ADDR_WIDTH-1:0]          init_cnt_r;
    logic [ADDR_WIDTH-1:0]          sample_cnt_r;
    logic [KW-1:0]                  node_idx_r;
    logic signed [DATA_WIDTH-1:0]   u_r;
    logic                           hist_req_r;
    logic signed [DATA_WIDTH-1:0]   nodes_r [VIRTUAL_NODES];

    logic                           last_node_s;
    logic                           abort_s;
    logic signed [DATA_WIDTH-1:0]   cur_x_s;
    logic signed [DATA_WIDTH-1:0]   fb_s;
    logic signed [EW-1:0]           u_ext_s;
    logic signed [EW-1:0]           term_s;
    logic signed [EW-1:0]           sum_s;
    logic signed [DATA_WIDTH-1:0]   new_x_s;

    // Clamp a wide signed value to the DATA_WIDTH two's-complement range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_fn(input logic signed [EW-1:0] v);
        logic signed [EW-1:0] max_v;
        logic signed [EW-1:0] min_v;
        max_v = {3'b000, {(DATA_WIDTH-1){1'b1}}};
        min_v = {3'b111, {(DATA_WIDTH-1){1'b0}}};
        if (v > max_v) begin
            return max_v[DATA_WIDTH-1:0];
        end else if (v < min_v) begin
            return min_v[DATA_WIDTH-1:0];
        end else begin
            return v[DATA_WIDTH-1:0];
        end
    endfunction

    // Either reset source kills a step in flight.
    assign abort_s     = rst | reservoir_rst;
    assign last_node_s = (node_idx_r == KW'(VIRTUAL_NODES - 1));

    // Node update arithmetic for the node addressed by node_idx_r.
    always_comb begin
        cur_x_s = nodes_r[node_idx_r];
        fb_s    = cur_x_s >>> FEEDBACK_SHIFT;
        u_ext_s = {{2{u_r[DATA_WIDTH-1]}}, u_r};
        if (MASK[node_idx_r]) begin
            term_s = u_ext_s;
        end else begin
            term_s = -u_ext_s;
        end
        sum_s   = term_s + {{2{fb_s[DATA_WIDTH-1]}}, fb_s};
        new_x_s = sat_fn(sum_s);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (abort_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (reservoir_en) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ:  state_s = ST_WAIT;
            ST_WAIT:  state_s = ST_UPDATE;
            ST_UPDATE: begin
                if (last_node_s) begin
                    state_s = ST_VALID;
                end else begin
                    state_s = ST_UPDATE;
                end
            end
            ST_VALID: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Step datapath: history request latch, sample capture, node walk.
    always_ff @(posedge clk) begin
        if (abort_s) begin
            node_idx_r <= '0;
            u_r        <= '0;
            hist_req_r <= 1'b0;
            for (int i = 0; i < VIRTUAL_NODES; i++) begin
                nodes_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    node_idx_r <= '0;
                    // History only counts when it arrives together with the start pulse.
                    hist_req_r <= reservoir_en & reservoir_history_en & (phase_r == PH_TEST);
                end
                ST_WAIT: begin
                    u_r <= sample_rd_data;
                end
                ST_UPDATE: begin
                    nodes_r[node_idx_r] <= new_x_s;
                    if (!last_node_s) begin
                        node_idx_r <= node_idx_r + KW'(1);
                    end
                end
                default: begin
                    node_idx_r <= node_idx_r;
                end
            endcase
        end
    end

    // Phase register and sample counters; reservoir_rst leaves these alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r      <= PH_NONE;
            init_cnt_r   <= '0;
            sample_cnt_r <= '0;
        end else begin
            if (init_sample_cntr_rst) begin
                phase_r    <= PH_INIT;
                init_cnt_r <= '0;
            end
            // Placed second so it wins when both counter resets coincide.
            if (sample_cntr_rst) begin
                phase_r      <= PH_TEST;
                sample_cnt_r <= '0;
            end
            if (sample_cntr_en && !init_sample_cntr_rst && !sample_cntr_rst) begin
                case (phase_r)
                    PH_INIT: init_cnt_r   <= init_cnt_r + ADDR_WIDTH'(1);
                    PH_TEST: sample_cnt_r <= sample_cnt_r + ADDR_WIDTH'(1);
                    default: init_cnt_r   <= init_cnt_r;
                endcase
            end
        end
    end

    // Status flags and sample read address decoded from registered state.
    always_comb begin
        reservoir_filled    = (phase_r == PH_TEST);
        reservoir_busy      = (phase_r == PH_TEST) && (sample_cnt_r < ADDR_WIDTH'(NUM_SAMPLES));
        reservoir_init_busy = (phase_r == PH_INIT) && (init_cnt_r < ADDR_WIDTH'(NUM_INIT_SAMPLES));
        case (phase_r)
            PH_INIT: sample_rd_addr = init_cnt_r;
            PH_TEST: sample_rd_addr = ADDR_WIDTH'(NUM_INIT_SAMPLES) + sample_cnt_r;
            default: sample_rd_addr = '0;
        endcase
    end

    // Handshake strobes and history write port; suppressed while aborting.
    always_comb begin
        sample_rd_en    = (state_r == ST_READ);
        reservoir_valid = (state_r == ST_VALID) && !abort_s;
        hist_wr_en      = (state_r == ST_UPDATE) && hist_req_r && !abort_s;
        if (hist_wr_en) begin
            hist_wr_addr = (sample_cnt_r * ADDR_WIDTH'(VIRTUAL_NODES)) + ADDR_WIDTH'(node_idx_r);
            hist_wr_data = new_x_s;
        end else begin
            hist_wr_addr = '0;
            hist_wr_data = '0;
        end
    end

endmodule

// File: tb/tb_dfr_reservoir_engine.sv
// ---------------------------------------------------------------------------
// tb_dfr_reservoir_engine
//
// Directed bench for dfr_reservoir_engine. Two instances share all control
// inputs: u_dut (DW=32) carries the functional scenarios, u_sat (DW=8) is
// used for saturation. Each has its own synchronous sample RAM model.
// Common setup: N=4, MASK=4'b0101, FEEDBACK_SHIFT=1, NUM_INIT=2, NUM_SAMPLES=3.
// ---------------------------------------------------------------------------
module tb_dfr_reservoir_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rrst = 1'b0;
    logic en = 1'b0;
    logic irst = 1'b0;
    logic srst = 1'b0;
    logic cen = 1'b0;
    logic hen = 1'b0;

    logic               busy1, ibusy1, filled1, valid1, rd_en1, hw_en1;
    logic [31:0]        rd_addr1, hw_addr1;
    logic signed [31:0] rd_data1, hw_data1;
    logic               busy2, ibusy2, filled2, valid2, rd_en2, hw_en2;
    logic [7:0]         rd_addr2, hw_addr2;
    logic signed [7:0]  rd_data2, hw_data2;

    logic signed [31:0] ram1 [8];
    logic signed [7:0]  ram2 [8];

    int errors = 0;
    int checks = 0;

    logic [31:0]        h1_addr [64];
    logic signed [31:0] h1_data [64];
    logic signed [7:0]  h2_data [64];
    int                 hcnt1;
    int                 hcnt2;
    logic [31:0]        last_rd_addr1;
    logic               got_valid;

    always #5 clk = ~clk;

    dfr_reservoir_engine #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .VIRTUAL_NODES(4), .NUM_INIT_SAMPLES(2),
        .NUM_SAMPLES(3), .FEEDBACK_SHIFT(1), .MASK(4'b0101)
    ) u_dut (
        .clk(clk), .rst(rst), .reservoir_rst(rrst), .reservoir_en(en),
        .init_sample_cntr_rst(irst), .sample_cntr_rst(srst), .sample_cntr_en(cen),
        .reservoir_history_en(hen), .reservoir_busy(busy1), .reservoir_init_busy(ibusy1),
        .reservoir_filled(filled1), .reservoir_valid(valid1), .sample_rd_en(rd_en1),
        .sample_rd_addr(rd_addr1), .sample_rd_data(rd_data1), .hist_wr_en(hw_en1),
        .hist_wr_addr(hw_addr1), .hist_wr_data(hw_data1)
    );

    dfr_reservoir_engine #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .VIRTUAL_NODES(4), .NUM_INIT_SAMPLES(2),
        .NUM_SAMPLES(3), .FEEDBACK_SHIFT(1), .MASK(4'b0101)
    ) u_sat (
        .clk(clk), .rst(rst), .reservoir_rst(rrst), .reservoir_en(en),
        .init_sample_cntr_rst(irst), .sample_cntr_rst(srst), .sample_cntr_en(cen),
        .reservoir_history_en(hen), .reservoir_busy(busy2), .reservoir_init_busy(ibusy2),
        .reservoir_filled(filled2), .reservoir_valid(valid2), .sample_rd_en(rd_en2),
        .sample_rd_addr(rd_addr2), .sample_rd_data(rd_data2), .hist_wr_en(hw_en2),
        .hist_wr_addr(hw_addr2), .hist_wr_data(hw_data2)
    );

    // Synchronous sample RAMs: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en1) rd_data1 <= ram1[rd_addr1[2:0]];
        if (rd_en2) rd_data2 <= ram2[rd_addr2[2:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One-cycle pulse of the counter/phase controls.
    task automatic ctl(input logic ir, input logic sr, input logic ce);
        @(posedge clk); #1;
        irst = ir; srst = sr; cen = ce;
        @(posedge clk); #1;
        irst = 1'b0; srst = 1'b0; cen = 1'b0;
    endtask

    // Start one step and collect read address / history writes until valid.
    task automatic run_step(input logic hist);
        @(posedge clk); #1;
        en = 1'b1; hen = hist;
        @(posedge clk); #1;
        en = 1'b0; hen = 1'b0;
        got_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_en1) last_rd_addr1 = rd_addr1;
            if (hw_en1 && hcnt1 < 64) begin
                h1_addr[hcnt1] = hw_addr1; h1_data[hcnt1] = hw_data1; hcnt1++;
            end
            if (hw_en2 && hcnt2 < 64) begin
                h2_data[hcnt2] = hw_data2; hcnt2++;
            end
            if (valid1) begin
                got_valid = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (got_valid !== 1'b1) begin
            errors++;
            $display("FAIL step_timeout: valid=%0b required 1", got_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy1, ibusy1, filled1, valid1, rd_en1, hw_en1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000", {busy1, ibusy1, filled1, valid1, rd_en1, hw_en1});
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_addr1 !== 32'd0 || hw_addr1 !== 32'd0 || hw_data1 !== 32'sd0) begin
            errors++;
            $display("FAIL reset_buses: rd_addr=%0d hist_addr=%0d hist_data=%0d required 0", rd_addr1, hw_addr1, hw_data1);
        end
        checks++;
        if ({busy2, ibusy2, filled2, valid2, rd_en2, hw_en2} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags_sat: got %b required 000000", {busy2, ibusy2, filled2, valid2, rd_en2, hw_en2});
        end
    endtask

    // First INIT step (u=10) with cycle-exact latency and an ignored second start.
    task automatic test_latency();
        ctl(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({ibusy1, filled1, busy1} !== 3'b100) begin
            errors++;
            $display("FAIL init_enter: init_busy/filled/busy=%b required 100", {ibusy1, filled1, busy1});
        end
        @(posedge clk); #1; en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            en = (c == 2);
            @(negedge clk);
            checks++;
            if (rd_en1 !== (c == 1)) begin
                errors++;
                $display("FAIL lat_rd_en t+%0d: got %0b required %0b", c, rd_en1, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (rd_addr1 !== 32'd0) begin
                    errors++;
                    $display("FAIL lat_rd_addr: got %0d required 0", rd_addr1);
                end
            end
            checks++;
            if (valid1 !== (c == 7)) begin
                errors++;
                $display("FAIL lat_valid t+%0d: got %0b required %0b", c, valid1, (c == 7));
            end
        end
    endtask

    // Second INIT step (u=20); history request in INIT must not write.
    task automatic test_init_steps();
        ctl(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (ibusy1 !== 1'b1 || rd_addr1 !== 32'd1) begin
            errors++;
            $display("FAIL init_cnt1: init_busy=%0b addr=%0d required 1/1", ibusy1, rd_addr1);
        end
        hcnt1 = 0; hcnt2 = 0;
        run_step(1'b1);
        checks++;
        if (hcnt1 != 0 || last_rd_addr1 !== 32'd1) begin
            errors++;
            $display("FAIL init_step2: hist_writes=%0d rd_addr=%0d required 0/1", hcnt1, last_rd_addr1);
        end
        ctl(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (ibusy1 !== 1'b0 || rd_addr1 !== 32'd2) begin
            errors++;
            $display("FAIL init_done: init_busy=%0b addr=%0d required 0/2", ibusy1, rd_addr1);
        end
    endtask

    // Three TEST steps with history: 12 writes carrying the INIT state forward.
    task automatic test_test_phase();
        int exp_d [12] = '{42, -43, 42, -43, 61, -62, 61, -62, 80, -81, 80, -81};
        ctl(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if ({filled1, busy1, ibusy1} !== 3'b110 || rd_addr1 !== 32'd2) begin
            errors++;
            $display("FAIL test_enter: filled/busy/init_busy=%b addr=%0d required 110/2", {filled1, busy1, ibusy1}, rd_addr1);
        end
        hcnt1 = 0; hcnt2 = 0;
        for (int s = 0; s < 3; s++) begin
            run_step(1'b1);
            ctl(1'b0, 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (busy1 !== (s < 2)) begin
                errors++;
                $display("FAIL test_busy step%0d: got %0b required %0b", s, busy1, (s < 2));
            end
        end
        checks++;
        if (hcnt1 != 12) begin
            errors++;
            $display("FAIL hist_count: got %0d required 12", hcnt1);
        end
        for (int i = 0; i < 12 && i < hcnt1; i++) begin
            checks++;
            if (h1_addr[i] !== 32'(i) || int'(h1_data[i]) != exp_d[i]) begin
                errors++;
                $display("FAIL hist_%0d: addr=%0d data=%0d required addr=%0d data=%0d", i, h1_addr[i], h1_data[i], i, exp_d[i]);
            end
        end
    endtask

    // Abort at UPDATE k=2, then confirm nodes cleared and counters kept.
    task automatic test_reservoir_rst();
        int n_valid = 0;
        int n_hist = 0;
        @(posedge clk); #1; en = 1'b1; hen = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            en = 1'b0; hen = 1'b0; rrst = (c == 5);
            @(negedge clk);
            if (valid1) n_valid++;
            if (hw_en1) n_hist++;
            if (c == 5) begin
                checks++;
                if (hw_en1 !== 1'b0) begin
                    errors++;
                    $display("FAIL rrst_hist_gate: hist_wr_en=%0b required 0", hw_en1);
                end
            end
        end
        checks++;
        if (n_valid != 0 || n_hist != 2) begin
            errors++;
            $display("FAIL rrst_abort: valids=%0d hist_writes=%0d required 0/2", n_valid, n_hist);
        end
        checks++;
        if ({filled1, busy1} !== 2'b10) begin
            errors++;
            $display("FAIL rrst_phase: filled/busy=%b required 10", {filled1, busy1});
        end
        hcnt1 = 0; hcnt2 = 0;
        run_step(1'b1);
        checks++;
        if (last_rd_addr1 !== 32'd5 || hcnt1 != 4) begin
            errors++;
            $display("FAIL rrst_next: rd_addr=%0d writes=%0d required 5/4", last_rd_addr1, hcnt1);
        end
        if (hcnt1 == 4) begin
            checks++;
            if (h1_addr[0] !== 32'd12 || int'(h1_data[0]) != 60 || int'(h1_data[1]) != -60
                || int'(h1_data[2]) != 60 || h1_addr[3] !== 32'd15) begin
                errors++;
                $display("FAIL rrst_nodes: addr0=%0d d=%0d,%0d,%0d addr3=%0d required 12 60,-60,60 15",
                         h1_addr[0], h1_data[0], h1_data[1], h1_data[2], h1_addr[3]);
            end
        end
    endtask

    // Counter reset beats enable; controller-style run sees five valids.
    task automatic test_priority();
        int valids = 0;
        ctl(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL prio_busy: got %0b required 1", busy1);
        end
        run_step(1'b0);
        checks++;
        if (last_rd_addr1 !== 32'd2) begin
            errors++;
            $display("FAIL prio_addr: got %0d required 2", last_rd_addr1);
        end
        ctl(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 10 && ibusy1; i++) begin
            run_step(1'b0);
            if (got_valid) valids++;
            ctl(1'b0, 1'b0, 1'b1);
            @(negedge clk);
        end
        ctl(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 10 && busy1; i++) begin
            run_step(1'b1);
            if (got_valid) valids++;
            ctl(1'b0, 1'b0, 1'b1);
            @(negedge clk);
        end
        checks++;
        if (valids != 5 || {filled1, busy1, ibusy1} !== 3'b100) begin
            errors++;
            $display("FAIL loop_run: valids=%0d flags=%b required 5/100", valids, {filled1, busy1, ibusy1});
        end
    endtask

    // 8-bit instance: -(-128) clamps, then repeated 127 drives both rails.
    task automatic test_saturation();
        int exp_s [16] = '{-128, 127, -128, 127, 63, -64, 63, -64,
                            127, -128, 127, -128, 127, -128, 127, -128};
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        ctl(1'b0, 1'b1, 1'b0);
        hcnt1 = 0; hcnt2 = 0;
        for (int s = 0; s < 4; s++) begin
            run_step(1'b1);
            ctl(1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (hcnt2 != 16) begin
            errors++;
            $display("FAIL sat_count: got %0d required 16", hcnt2);
        end
        for (int i = 0; i < 16 && i < hcnt2; i++) begin
            checks++;
            if (int'(h2_data[i]) != exp_s[i]) begin
                errors++;
                $display("FAIL sat_%0d: got %0d required %0d", i, h2_data[i], exp_s[i]);
            end
        end
    endtask

    initial begin
        ram1 = '{32'sd10, 32'sd20, 32'sd30, 32'sd40, 32'sd50, 32'sd60, 32'sd0, 32'sd0};
        ram2 = '{8'sd0, 8'sd0, -8'sd128, 8'sd127, 8'sd127, 8'sd127, 8'sd0, 8'sd0};
        hcnt1 = 0; hcnt2 = 0;
        last_rd_addr1 = 32'd0;
        got_valid = 1'b0;
        test_reset();
        test_latency();
        test_init_steps();
        test_test_phase();
        test_reservoir_rst();
        test_priority();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
